// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding register.
// A word accepted while idle appears on ser_out the cycle after it is
// captured. A word held in the holding register follows the current word
// with no gap.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | shifter empty, ser_out = IDLE_BIT, ser_valid = 0
// SHIFT | shifter presents the bit selected by bit_cnt on ser_out
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [CNT_W-1:0] bit_cnt;

    logic fire;
    logic last_bit;
    logic load_slot;

    // Handshake and load-slot decode use registered state only, so s_ready
    // has no combinational path from s_valid.
    always_comb begin
        s_ready   = !hold_full && !rst;
        fire      = s_valid && s_ready;
        last_bit  = (state == SHIFT) && (bit_cnt == LAST_BIT);
        load_slot = (state == IDLE) || last_bit;
    end

    // The serial outputs are decoded from registers only.
    always_comb begin
        ser_valid = (state == SHIFT);
        word_done = last_bit;
        busy      = (state == SHIFT) || hold_full;
        if (state == SHIFT) begin
            ser_out = MSB_FIRST ? shifter[WIDTH-1] : shifter[0];
        end else begin
            ser_out = IDLE_BIT;
        end
    end

    // Load, shift and holding-register control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shifter   <= '0;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
        end else if (load_slot) begin
            bit_cnt <= '0;
            if (hold_full) begin
                // Held word goes first; a coincident new word refills the hold.
                shifter <= hold_reg;
                state   <= SHIFT;
                if (fire) begin
                    hold_reg <= s_data;
                end else begin
                    hold_full <= 1'b0;
                end
            end else if (fire) begin
                shifter <= s_data;
                state   <= SHIFT;
            end else begin
                state <= IDLE;
            end
        end else begin
            // Mid-word: advance one bit; a new word can only be parked.
            if (MSB_FIRST) begin
                shifter <= shifter << 1;
            end else begin
                shifter <= shifter >> 1;
            end
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (fire) begin
                hold_reg  <= s_data;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer. There are three instances that share
// one stimulus: MSB-first with idle 0, LSB-first with idle 0, and
// MSB-first with idle 1.
module tb_bit_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;

    logic rdy_m, so_m, sv_m, wd_m, busy_m;
    logic rdy_l, so_l, sv_l, wd_l, busy_l;
    logic rdy_i, so_i, sv_i, wd_i, busy_i;

    int n_tests = 0;
    int n_fail  = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy_m), .ser_out(so_m), .ser_valid(sv_m),
        .word_done(wd_m), .busy(busy_m)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy_l), .ser_out(so_l), .ser_valid(sv_l),
        .word_done(wd_l), .busy(busy_l)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut_i (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy_i), .ser_out(so_i), .ser_valid(sv_i),
        .word_done(wd_i), .busy(busy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       e_so_m;
        logic       e_so_l;
        logic       e_sv;
        logic       e_wd;
        logic       e_busy;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add_row(input logic r, input logic v, input logic [7:0] d,
                           input logic som, input logic sol, input logic sv,
                           input logic wd, input logic bsy, input logic rdy);
        vec_t e;
        e.r = r; e.v = v; e.d = d;
        e.e_so_m = som; e.e_so_l = sol; e.e_sv = sv;
        e.e_wd = wd; e.e_busy = bsy; e.e_rdy = rdy;
        tbl.push_back(e);
    endtask

    // Eight shifting rows. m and l give the expected bit order on ser_out,
    // first bit in the MSB position. The first row may present a new word.
    task automatic add_word(input logic [7:0] m, input logic [7:0] l,
                            input logic v0, input logic [7:0] d0,
                            input logic r0, input logic r_rest);
        for (int i = 0; i < 8; i++) begin
            add_row(1'b0, (i == 0) ? v0 : 1'b0, d0, m[7-i], l[7-i], 1'b1,
                    (i == 7), 1'b1, (i == 0) ? r0 : r_rest);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        rst     = r;
        s_valid = v;
        s_data  = d;
        @(negedge clk);
    endtask

    logic [7:0]  words[3];
    logic [23:0] stream_m;
    logic [23:0] stream_l;
    int          nbits, first_c, last_c, idx, wd_n, sv_seen, busy_seen;
    int          fire_c[3];
    int          wd_c[3];

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(posedge clk);

        // Reset row, then the first idle cycle after release.
        add_row(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_row(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Single word 0xD4: MSB order 11010100, LSB order 00101011.
        add_row(1'b0, 1'b1, 8'hD4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_word(8'b11010100, 8'b00101011, 1'b0, 8'h00, 1'b1, 1'b1);
        add_row(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Back-to-back 0xD4 then 0xA5. s_ready stays low while 0xA5 is held.
        add_row(1'b0, 1'b1, 8'hD4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_word(8'b11010100, 8'b00101011, 1'b1, 8'hA5, 1'b1, 1'b0);
        add_word(8'b10100101, 8'b10100101, 1'b0, 8'h00, 1'b1, 1'b1);
        add_row(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Word 0x01: MSB order 00000001, LSB order 10000000.
        add_row(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_word(8'b00000001, 8'b10000000, 1'b0, 8'h00, 1'b1, 1'b1);
        add_row(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].d);
            chk("so_msb",  i, 32'(so_m),   32'(tbl[i].e_so_m));
            chk("so_lsb",  i, 32'(so_l),   32'(tbl[i].e_so_l));
            chk("so_idle1", i, 32'(so_i),  32'(tbl[i].e_sv ? tbl[i].e_so_m : 1'b1));
            chk("ser_valid", i, 32'(sv_m), 32'(tbl[i].e_sv));
            chk("word_done", i, 32'(wd_m), 32'(tbl[i].e_wd));
            chk("busy",    i, 32'(busy_m), 32'(tbl[i].e_busy));
            chk("s_ready", i, 32'(rdy_m),  32'(tbl[i].e_rdy));
        end

        // Backpressure: three words offered continuously. The third word
        // fires only after the holding register drains at the first word's
        // last bit.
        words[0] = 8'hC5; words[1] = 8'h81; words[2] = 8'h5A;
        stream_m = '0; stream_l = '0;
        nbits = 0; first_c = -1; last_c = -1; idx = 0; wd_n = 0;
        for (int k = 0; k < 3; k++) begin
            fire_c[k] = -1;
            wd_c[k]   = -1;
        end
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, (idx < 3), words[(idx < 3) ? idx : 0]);
            if (sv_m) begin
                stream_m = {stream_m[22:0], so_m};
                stream_l = {stream_l[22:0], so_l};
                nbits++;
                if (first_c < 0) first_c = k;
                last_c = k;
            end
            if (wd_m) begin
                if (wd_n < 3) wd_c[wd_n] = k;
                wd_n++;
            end
            if (s_valid && rdy_m && idx < 3) begin
                fire_c[idx] = k;
                idx++;
            end
        end
        chk("bp_fires", 0, 32'(idx), 32'd3);
        chk("bp_fire0", 0, 32'(fire_c[0]), 32'd0);
        chk("bp_fire1", 0, 32'(fire_c[1]), 32'd1);
        chk("bp_fire2", 0, 32'(fire_c[2]), 32'd9);
        chk("bp_nbits", 0, 32'(nbits), 32'd24);
        chk("bp_first", 0, 32'(first_c), 32'd1);
        chk("bp_last",  0, 32'(last_c), 32'd24);
        chk("bp_stream_msb", 0, 32'(stream_m), 32'h00C5815A);
        chk("bp_stream_lsb", 0, 32'(stream_l), 32'h00A3815A);
        chk("bp_wd_count", 0, 32'(wd_n), 32'd3);
        chk("bp_wd0", 0, 32'(wd_c[0]), 32'd8);
        chk("bp_wd1", 0, 32'(wd_c[1]), 32'd16);
        chk("bp_wd2", 0, 32'(wd_c[2]), 32'd24);

        // Reset during the fourth bit of 0xFF while 0x0F is held.
        cyc(1'b0, 1'b1, 8'hFF);
        cyc(1'b0, 1'b1, 8'h0F);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        chk("rm_pre_busy", 0, 32'(busy_m), 32'd1);
        chk("rm_pre_rdy",  0, 32'(rdy_m),  32'd0);
        cyc(1'b1, 1'b0, 8'h00);
        chk("rm_rst_rdy", 0, 32'(rdy_m), 32'd0);
        chk("rm_rst_sv",  0, 32'(sv_m),  32'd1);
        cyc(1'b0, 1'b0, 8'h00);
        chk("rm_post_sv",   0, 32'(sv_m),   32'd0);
        chk("rm_post_so",   0, 32'(so_m),   32'd0);
        chk("rm_post_so1",  0, 32'(so_i),   32'd1);
        chk("rm_post_wd",   0, 32'(wd_m),   32'd0);
        chk("rm_post_busy", 0, 32'(busy_m), 32'd0);
        chk("rm_post_rdy",  0, 32'(rdy_m),  32'd1);
        sv_seen = 0; busy_seen = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, 1'b0, 8'h00);
            if (sv_m || sv_l || sv_i) sv_seen++;
            if (busy_m) busy_seen++;
        end
        chk("rm_residual_bits", 0, 32'(sv_seen), 32'd0);
        chk("rm_residual_busy", 0, 32'(busy_seen), 32'd0);

        // Idle fill with IDLE_BIT = 1 and no input.
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 8'h00);
            chk("idle_fill_so", k, 32'(so_i), 32'd1);
            chk("idle_fill_sv", k, 32'(sv_i), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per input word (2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 transmitted first, 0 = bit 0 first.
REQ-003 SHALL have parameter IDLE_BIT, default 0: ser_out level when no word is being shifted.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_data  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port s_valid  input  1  s_data valid.
REQ-008 SHALL have port s_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port ser_out  output  1  serial bit stream, one bit per clk, feeds the downstream pattern detector's serial input.
REQ-010 SHALL have port ser_valid  output  1  ser_out carries a word bit, not idle fill.
REQ-011 SHALL have port word_done  output  1  one-cycle pulse coincident with the last bit of each word on ser_out.
REQ-012 SHALL have port busy  output  1  shifter loaded or holding register full.

Function
REQ-013 SHALL contain a WIDTH-bit shift register (shifter), a WIDTH-bit holding register with full flag (hold_full), and a bit counter of ceil(log2(WIDTH)) bits.
REQ-014 SHALL implement two states: IDLE (shifter empty) and SHIFT (shifter presenting a word bit).
REQ-015 SHALL define handshake fire = s_valid && s_ready at a rising edge; s_data captured only on fire.
REQ-016 SHALL drive s_ready = !hold_full && !rst, combinationally from registered state only (no path from s_valid).
REQ-017 SHALL define load_slot = (state == IDLE) || (state == SHIFT && bit counter == WIDTH-1).
REQ-018 SHALL, at an edge with load_slot: load shifter from holding register if hold_full (clearing hold_full), else from s_data if fire, else go to IDLE.
REQ-019 SHALL, when hold_full and load_slot and fire coincide, move holding into shifter and write s_data into holding in the same edge (hold_full stays 1).
REQ-020 SHALL, on fire not consumed by REQ-018, write s_data into holding register and set hold_full.
REQ-021 SHALL, in SHIFT and not load_slot, advance shifter one bit and increment bit counter each cycle; counter resets to 0 on every load.
REQ-022 SHALL present the first bit of a word on ser_out in the cycle after it is loaded into the shifter; a word accepted while IDLE appears on ser_out 1 cycle after fire.
REQ-023 SHALL emit back-to-back words with no idle cycle between them whenever a next word is available at load_slot.
REQ-024 SHALL drive ser_out = IDLE_BIT and ser_valid = 0 in IDLE; ser_valid = 1 in SHIFT.
REQ-025 SHALL assert word_done when state == SHIFT and bit counter == WIDTH-1.
REQ-026 SHALL drive busy = (state == SHIFT) || hold_full.
REQ-027 SHALL hold all stored data unchanged while s_valid is low and no shift occurs; s_data is ignored when s_ready is 0.
REQ-028 SHALL have ser_out, ser_valid, word_done glitch-free (registered or decoded from registers only).

Reset
REQ-029 SHALL, on any edge with rst = 1, set state = IDLE, hold_full = 0, bit counter = 0, shifter = 0, regardless of operation in progress.
REQ-030 SHALL during and after reset drive ser_out = IDLE_BIT, ser_valid = 0, word_done = 0, busy = 0, s_ready = 0 while rst = 1 and 1 in first cycle after release.
REQ-031 SHALL discard any partially shifted or held word on reset mid-operation; no remaining bits emitted after release.

Verification
REQ-032 SHALL cover single word: WIDTH=8, MSB_FIRST=1, s_data=0xD4 fire at cycle 0 -> ser_out 1,1,0,1,0,1,0,0 on cycles 1-8, ser_valid=1 cycles 1-8, word_done at cycle 8, ser_out=0 cycle 9.
REQ-033 SHALL cover back-to-back: 0xD4 then 0xA5 with s_valid held high -> 16 consecutive valid bits, no gap, word_done at cycles 8 and 16, s_ready low while hold_full.
REQ-034 SHALL cover LSB-first: MSB_FIRST=0, s_data=0x01 -> ser_out 1,0,0,0,0,0,0,0.
REQ-035 SHALL cover backpressure: three words presented continuously -> third fire delayed until holding register drains at first word's last bit; output order preserved.
REQ-036 SHALL cover reset mid-word: rst asserted at bit 4 of 0xFF with held word pending -> ser_valid=0, ser_out=IDLE_BIT from next cycle, busy=0, no residual bits after release.
REQ-037 SHALL cover idle fill: IDLE_BIT=1, no input -> ser_out=1, ser_valid=0 continuously.
